// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Streaming 3x3 sliding-window generator. Raster-order pixels arrive on a
//   valid/ready handshake. Two line buffers keep the previous two rows, and a
//   3x3 column shift register assembles the window. One registered window is
//   presented per valid-padding output position (no edge fill).
//
// Ports
//   rd_clk      read-domain clock, rising edge
//   rd_rst      synchronous active-high reset
//   in_valid    upstream pixel valid
//   in_data     pixel value (DATA_WIDTH)
//   in_ready    block accepts a pixel this cycle
//   win_valid   win_data holds a valid window
//   win_ready   downstream accepts the window
//   win_data    9 pixels, element (r,c) at [DATA_WIDTH*(3*r+c) +: DATA_WIDTH],
//               r=0 oldest row, c=0 leftmost column
//   frame_done  one-cycle pulse after the last window of a frame is accepted
module conv_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    frame_done
);

    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam int WIN_TOTAL = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
    localparam int CNT_W     = $clog2(WIN_TOTAL + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_TOTAL - 1);

    logic [COL_W-1:0]        col_r;
    logic [ROW_W-1:0]        row_r;
    logic [CNT_W-1:0]        win_cnt_r;
    logic [DATA_WIDTH-1:0]   lb_top_r [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   lb_mid_r [IMG_WIDTH];
    logic [9*DATA_WIDTH-1:0] shift_r;
    logic [9*DATA_WIDTH-1:0] win_data_r;
    logic                    win_valid_r;
    logic                    frame_done_r;

    logic                    in_accept_s;
    logic                    out_fire_s;
    logic                    win_load_s;
    logic [DATA_WIDTH-1:0]   top_rd_s;
    logic [DATA_WIDTH-1:0]   mid_rd_s;
    logic [9*DATA_WIDTH-1:0] shift_next_s;

    // The single output entry frees up in the same cycle it is consumed.
    assign in_ready    = !win_valid_r || win_ready;
    assign in_accept_s = in_valid && in_ready;
    assign out_fire_s  = win_valid_r && win_ready;
    assign win_load_s  = in_accept_s && (row_r >= ROW_MIN) && (col_r >= COL_MIN);
    assign top_rd_s    = lb_top_r[col_r];
    assign mid_rd_s    = lb_mid_r[col_r];

    assign win_valid  = win_valid_r;
    assign win_data   = win_data_r;
    assign frame_done = frame_done_r;

    // Shift the window one column left and insert the new right-hand column.
    always_comb begin
        shift_next_s = shift_r;
        for (int r = 0; r < 3; r++) begin
            shift_next_s[DATA_WIDTH*(3*r+0) +: DATA_WIDTH] = shift_r[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
            shift_next_s[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = shift_r[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
        end
        shift_next_s[DATA_WIDTH*2 +: DATA_WIDTH] = top_rd_s;
        shift_next_s[DATA_WIDTH*5 +: DATA_WIDTH] = mid_rd_s;
        shift_next_s[DATA_WIDTH*8 +: DATA_WIDTH] = in_data;
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Line buffers: contents persist across frames; rows 0-1 of each frame
    // never reach a window, so stale data from the previous frame is masked.
    always_ff @(posedge rd_clk) begin
        if (in_accept_s && !rd_rst) begin
            lb_top_r[col_r] <= mid_rd_s;
            lb_mid_r[col_r] <= in_data;
        end
    end

    // Column shift register; not cleared at row start since no window is
    // emitted until two fresh columns of the current row have entered.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            shift_r <= '0;
        end else if (in_accept_s) begin
            shift_r <= shift_next_s;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Output entry: a new window overrides the one being consumed this cycle.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            win_valid_r <= 1'b0;
            win_data_r  <= '0;
        end else if (win_load_s) begin
            win_valid_r <= 1'b1;
            win_data_r  <= shift_next_s;
        end else if (out_fire_s) begin
            win_valid_r <= 1'b0;
            win_data_r  <= win_data_r;
        end else begin
            win_valid_r <= win_valid_r;
            win_data_r  <= win_data_r;
        end
    end

    // Count accepted windows; pulse frame_done after the final one.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            win_cnt_r    <= '0;
            frame_done_r <= 1'b0;
        end else if (out_fire_s) begin
            if (win_cnt_r == CNT_LAST) begin
                win_cnt_r    <= '0;
                frame_done_r <= 1'b1;
            end else begin
                win_cnt_r    <= win_cnt_r + CNT_W'(1);
                frame_done_r <= 1'b0;
            end
        end else begin
            win_cnt_r    <= win_cnt_r;
            frame_done_r <= 1'b0;
        end
    end

endmodule
